// File: rtl/hls_run_sequencer_if.sv
// hls_run_sequencer_if: host streams, accelerator start/done and slave RAM port of the run sequencer
interface hls_run_sequencer_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int SIZE_W = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic                  acc_start_port;
    logic                  acc_done_port;
    logic [1:0]            S_oe_ram;
    logic [1:0]            S_we_ram;
    logic [2*ADDR_W-1:0]   S_addr_ram;
    logic [2*DATA_W-1:0]   S_Wdata_ram;
    logic [2*SIZE_W-1:0]   S_data_ram_size;
    logic [2*DATA_W-1:0]   Sout_Rdata_ram;
    logic [1:0]            Sout_DataRdy;
    modport master (
        input  in_valid, in_data, out_ready, acc_done_port, Sout_Rdata_ram, Sout_DataRdy,
        output in_ready, out_valid, out_data, acc_start_port, S_oe_ram, S_we_ram, S_addr_ram,
               S_Wdata_ram, S_data_ram_size
    );
    modport slave (
        output in_valid, in_data, out_ready, acc_done_port, Sout_Rdata_ram, Sout_DataRdy,
        input  in_ready, out_valid, out_data, acc_start_port, S_oe_ram, S_we_ram, S_addr_ram,
               S_Wdata_ram, S_data_ram_size
    );
endinterface

// File: rtl/hls_run_sequencer.sv
// hls_run_sequencer: loads, starts, times and drains one accelerator run; define HLS_SEQ_SORT_CHECK_EN to flag unsorted readback
module hls_run_sequencer #(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 8,
    parameter int SIZE_W         = 4,
    parameter int N_WORDS        = 28,
    parameter int BASE_ADDR      = 0,
    parameter int CYC_W          = 32,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_start,
    output logic                 busy,
    hls_run_sequencer_if.master  bus,
    output logic [CYC_W-1:0]     run_cycles,
    output logic [1:0]           status,
    output logic                 status_valid
);
    typedef enum logic [2:0] {IDLE, LOAD, KICK, RUN, DRAIN, REPORT} state_t;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [CYC_W-1:0]  LIMIT = CYC_W'(TIMEOUT_CYCLES);
    state_t state, next_state;
    logic [ADDR_W-1:0] idx, wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data, rd_data;
    logic wr_pend, load_full, rd_out;
    logic accept, rd_issue, rd_capture, out_hs, last_hs, timeout;
    logic [1:0] ok_status;
    logic unused_ok;

    assign accept     = bus.in_valid && bus.in_ready;
    assign rd_issue   = state == DRAIN && !bus.out_valid && !rd_out;
    assign rd_capture = rd_out && bus.Sout_DataRdy[0];
    assign rd_data    = bus.Sout_Rdata_ram[DATA_W-1:0];
    assign rd_addr    = BASE + idx;
    assign out_hs     = bus.out_valid && bus.out_ready;
    assign last_hs    = state == DRAIN && out_hs && idx == LAST;
    assign timeout    = run_cycles == LIMIT;
    assign unused_ok  = ^{bus.Sout_Rdata_ram[2*DATA_W-1:DATA_W], bus.Sout_DataRdy[1]};

    // state register
    always_ff @(posedge clock) begin
        state <= reset ? IDLE : next_state;
    end

    // run phase sequencing; done beats a coincident timeout
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = cmd_start ? LOAD : IDLE;
            LOAD:    next_state = load_full ? KICK : LOAD;
            KICK:    next_state = RUN;
            RUN:     next_state = bus.acc_done_port ? DRAIN : timeout ? REPORT : RUN;
            DRAIN:   next_state = last_hs ? REPORT : DRAIN;
            REPORT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // handshakes and slave port; only channel 0 is ever driven
    always_comb begin
        busy                = state != IDLE;
        status_valid        = state == REPORT;
        bus.in_ready        = state == LOAD && !load_full;
        bus.acc_start_port  = state == KICK;
        bus.S_oe_ram        = {1'b0, rd_issue};
        bus.S_we_ram        = {1'b0, wr_pend};
        bus.S_addr_ram      = {ADDR_W'(0), rd_issue ? rd_addr : wr_pend ? wr_addr : ADDR_W'(0)};
        bus.S_Wdata_ram     = {DATA_W'(0), wr_pend ? wr_data : DATA_W'(0)};
        bus.S_data_ram_size = {SIZE_W'(0), (rd_issue || wr_pend) ? SIZE_W'(DATA_W) : SIZE_W'(0)};
    end

    // element index, write pipeline, single outstanding read, output register, cycle count and status
    always_ff @(posedge clock) begin
        if (reset) begin
            idx           <= '0;
            wr_addr       <= '0;
            wr_data       <= '0;
            wr_pend       <= 1'b0;
            load_full     <= 1'b0;
            rd_out        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            run_cycles    <= '0;
            status        <= 2'b00;
        end else begin
            idx <= (state == IDLE || state == RUN) ? '0 : (accept || (state == DRAIN && out_hs)) ? idx + 1'b1 : idx;
            wr_pend   <= accept;
            load_full <= accept && idx == LAST;
            if (accept) begin
                wr_addr <= rd_addr;
                wr_data <= bus.in_data;
            end
            rd_out        <= rd_issue || (rd_out && !bus.Sout_DataRdy[0]);
            bus.out_valid <= rd_capture || (bus.out_valid && !bus.out_ready);
            if (rd_capture) bus.out_data <= rd_data;
            if (state == KICK) run_cycles <= '0;
            else if (state == RUN && (bus.acc_done_port || !timeout) && !(&run_cycles)) run_cycles <= run_cycles + 1'b1;
            if (state == RUN && !bus.acc_done_port && timeout) status <= 2'b10;
            else if (last_hs) status <= ok_status;
        end
    end

`ifdef HLS_SEQ_SORT_CHECK_EN
    logic sort_err;
    // sticky flag: a captured element smaller than the one before it; out_data still holds the predecessor
    always_ff @(posedge clock) begin
        if (reset || state == KICK) sort_err <= 1'b0;
        else if (rd_capture && idx != '0 && rd_data < bus.out_data) sort_err <= 1'b1;
    end
    assign ok_status = {sort_err, 1'b1};
`else
    assign ok_status = 2'b01;
`endif
endmodule

// File: tb/tb_hls_run_sequencer.sv
// tb_hls_run_sequencer: scoreboard bench; dut_t shares the stimulus and carries TIMEOUT_CYCLES=50
module tb_hls_run_sequencer;
    typedef logic [7:0] arr_t [28];
    typedef struct packed {logic [6:0] a; logic [7:0] d;} wr_t;
    typedef struct packed {logic [1:0] s; logic [31:0] c;} rep_t;

    logic clock = 1'b0, reset = 1'b1, cmd = 1'b0, sel = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b1, toggle = 1'b0, var_lat = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic busy_a, busy_t, sv_a, sv_t;
    logic [31:0] cyc_a, cyc_t;
    logic [1:0] st_a, st_t;
    int tests = 0, fails = 0, exp_starts = 0, hs_cnt = 0;
    wr_t exp_wr[$];
    logic [6:0] exp_rd[$];
    logic [7:0] exp_out[$];
    rep_t exp_rep[$];

    hls_run_sequencer_if a_if ();
    hls_run_sequencer_if t_if ();

    hls_run_sequencer dut_a (
        .clock(clock), .reset(reset), .cmd_start(cmd && !sel), .busy(busy_a), .bus(a_if.master),
        .run_cycles(cyc_a), .status(st_a), .status_valid(sv_a)
    );
    hls_run_sequencer #(.TIMEOUT_CYCLES(50)) dut_t (
        .clock(clock), .reset(reset), .cmd_start(cmd && sel), .busy(busy_t), .bus(t_if.master),
        .run_cycles(cyc_t), .status(st_t), .status_valid(sv_t)
    );

    always #5 clock = ~clock;

    int acc_cnt = 0, rd_wait = 0, rd_n = 0;
    logic rdy = 1'b0;
    logic [7:0] rdata = 8'h00;
    logic [6:0] rd_a = 7'h00;
    logic [7:0] mem [128];

    assign a_if.in_valid = in_valid;
    assign t_if.in_valid = in_valid;
    assign a_if.in_data = in_data;
    assign t_if.in_data = in_data;
    assign a_if.out_ready = out_ready;
    assign t_if.out_ready = out_ready;
    assign a_if.acc_done_port = acc_cnt == 100;
    assign t_if.acc_done_port = 1'b0;
    assign a_if.Sout_DataRdy = {1'b0, rdy};
    assign t_if.Sout_DataRdy = {1'b0, rdy};
    assign a_if.Sout_Rdata_ram = {8'h00, rdata};
    assign t_if.Sout_Rdata_ram = {8'h00, rdata};

    logic m_we, m_oe, m_start, m_ready, m_ovalid, m_busy, m_sv;
    logic [6:0] m_addr;
    logic [7:0] m_wdata, m_odata, m_size;
    logic [1:0] m_status;
    logic [31:0] m_cyc;
    assign m_we     = sel ? t_if.S_we_ram[0] : a_if.S_we_ram[0];
    assign m_oe     = sel ? t_if.S_oe_ram[0] : a_if.S_oe_ram[0];
    assign m_start  = sel ? t_if.acc_start_port : a_if.acc_start_port;
    assign m_ready  = sel ? t_if.in_ready : a_if.in_ready;
    assign m_ovalid = sel ? t_if.out_valid : a_if.out_valid;
    assign m_odata  = sel ? t_if.out_data : a_if.out_data;
    assign m_addr   = sel ? t_if.S_addr_ram[6:0] : a_if.S_addr_ram[6:0];
    assign m_wdata  = sel ? t_if.S_Wdata_ram[7:0] : a_if.S_Wdata_ram[7:0];
    assign m_size   = sel ? t_if.S_data_ram_size : a_if.S_data_ram_size;
    assign m_busy   = sel ? busy_t : busy_a;
    assign m_sv     = sel ? sv_t : sv_a;
    assign m_status = sel ? st_t : st_a;
    assign m_cyc    = sel ? cyc_t : cyc_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name, input int act, input int exp);
        tests++;
        fails++;
        $display("FAIL %s: actual %0d events, required %0d", name, act, exp);
    endtask

    // accelerator model: done one cycle, 100 cycles after the start pulse
    always @(posedge clock) begin
        acc_cnt <= a_if.acc_start_port ? 1 : (acc_cnt == 0 || acc_cnt == 100) ? 0 : acc_cnt + 1;
    end

    // slave RAM model: latency 2, or cycling 2..5 when var_lat is set
    always @(posedge clock) begin
        rdy <= 1'b0;
        if (m_we) mem[m_addr] <= m_wdata;
        if (m_oe) begin
            rd_a <= m_addr;
            rd_wait <= var_lat ? 1 + rd_n % 4 : 1;
            rd_n <= rd_n + 1;
        end else if (rd_wait == 1) begin
            rd_wait <= 0;
            rdy <= 1'b1;
            rdata <= mem[rd_a];
        end else if (rd_wait > 1) rd_wait <= rd_wait - 1;
    end

    always @(posedge clock) begin
        #1 out_ready = toggle ? !out_ready : 1'b1;
    end

    // monitor: pops the scoreboard whenever the DUT presents a write, read, element, start or report
    logic pv = 1'b0, pr = 1'b0, psv = 1'b0;
    logic [7:0] pd = 8'h00;
    always @(negedge clock) begin : mon
        wr_t w;
        rep_t r;
        if (reset) begin
            pv = 1'b0;
            psv = 1'b0;
        end else begin
            if (m_we && m_oe) bad("we_and_oe", 2, 1);
            if (m_we || m_oe) chk("ram_size", m_size, 8);
            else if (m_size != 0) bad("ram_size_idle", 1, 0);
            if (m_we) begin
                if (exp_wr.size() == 0) bad("unexpected_write", 1, 0);
                else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", m_addr, w.a);
                    chk("wr_data", m_wdata, w.d);
                end
            end
            if (m_oe) begin
                chk("one_outstanding", rd_wait == 0 && !rdy, 1);
                if (exp_rd.size() == 0) bad("unexpected_read", 1, 0);
                else chk("rd_addr", m_addr, exp_rd.pop_front());
            end
            if (pv && !pr) begin
                chk("out_valid_hold", m_ovalid, 1);
                chk("out_data_hold", m_odata, pd);
            end
            if (m_ovalid && out_ready) begin
                hs_cnt++;
                if (exp_out.size() == 0) bad("unexpected_output", 1, 0);
                else chk("out_data", m_odata, exp_out.pop_front());
            end
            if (m_start) begin
                if (exp_starts == 0) bad("unexpected_start", 1, 0);
                else exp_starts--;
            end
            if (psv) chk("busy_after_report", m_busy, 0);
            if (m_sv) begin
                if (exp_rep.size() == 0) bad("unexpected_report", 1, 0);
                else begin
                    r = exp_rep.pop_front();
                    chk("status", m_status, r.s);
                    chk("run_cycles", m_cyc, r.c);
                    chk("busy_in_report", m_busy, 1);
                end
            end
            pv = m_ovalid;
            pr = out_ready;
            pd = m_odata;
            psv = m_sv;
        end
    end

    function automatic logic [1:0] exp_ok(input arr_t d);
`ifdef HLS_SEQ_SORT_CHECK_EN
        for (int i = 1; i < 28; i++) if (d[i] < d[i-1]) return 2'b11;
`endif
        return 2'b01;
    endfunction

    task automatic load(input arr_t d, input bit gap);
        bit acc;
        for (int i = 0; i < 28; i++) begin
            in_valid = 1'b1;
            in_data = d[i];
            acc = 1'b0;
            for (int n = 0; n < 50 && !acc; n++) begin
                @(negedge clock);
                acc = m_ready;
                @(posedge clock);
                #1;
            end
            if (!acc) bad("load_stall", 0, 1);
            if (gap && i == 5) begin
                in_valid = 1'b0;
                @(posedge clock);
                #1;
            end
        end
        in_valid = 1'b0;
        @(negedge clock);
        chk("in_ready_after_load", m_ready, 0);
    endtask

    task automatic start_run(input arr_t d, input bit rd, input bit rep, input logic [1:0] st, input logic [31:0] cyc, input bit gap);
        for (int i = 0; i < 28; i++) begin
            exp_wr.push_back({7'(i), d[i]});
            if (rd) begin
                exp_rd.push_back(7'(i));
                exp_out.push_back(d[i]);
            end
        end
        if (rep) exp_rep.push_back({st, cyc});
        exp_starts++;
        cmd = 1'b1;
        load(d, gap);
    endtask

    task automatic wait_report();
        bit seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(posedge clock);
            #1;
            seen = m_sv;
        end
        cmd = 1'b0;
        if (!seen) bad("report_wait", 0, 1);
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs();
        @(negedge clock);
        chk("rst_busy", m_busy, 0);
        chk("rst_status", m_status, 0);
        chk("rst_run_cycles", m_cyc, 0);
        chk("rst_status_valid", m_sv, 0);
        chk("rst_in_ready", m_ready, 0);
        chk("rst_out_valid", m_ovalid, 0);
        chk("rst_out_data", m_odata, 0);
        chk("rst_we_oe", {m_we, m_oe}, 0);
        chk("rst_start", m_start, 0);
        chk("rst_addr", m_addr, 0);
    endtask

    initial begin
        arr_t down, up, bump;
        int base;
        for (int i = 0; i < 28; i++) begin
            down[i] = 8'(27 - i);
            up[i] = 8'(i * 9);
            bump[i] = i < 3 ? 8'(i) : i == 3 ? 8'd5 : i == 4 ? 8'd4 : 8'(i + 1);
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check_idle_outputs();
        @(posedge clock);
        #1;
        start_run(down, 1, 1, exp_ok(down), 100, 0);
        wait_report();
        toggle = 1'b1;
        var_lat = 1'b1;
        start_run(up, 1, 1, exp_ok(up), 100, 1);
        wait_report();
        toggle = 1'b0;
        var_lat = 1'b0;
        start_run(bump, 1, 1, exp_ok(bump), 100, 0);
        wait_report();
        sel = 1'b1;
        start_run(up, 0, 1, 2'b10, 50, 0);
        wait_report();
        sel = 1'b0;
        base = hs_cnt;
        start_run(down, 1, 0, 2'b00, 0, 0);
        for (int n = 0; n < 3000 && hs_cnt < base + 5; n++) begin
            @(posedge clock);
            #1;
        end
        if (hs_cnt < base + 5) bad("drain_wait", hs_cnt - base, 5);
        reset = 1'b1;
        cmd = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        exp_rd.delete();
        exp_out.delete();
        check_idle_outputs();
        repeat (20) @(posedge clock);
        #1;
        chk("writes_left", exp_wr.size(), 0);
        chk("reports_left", exp_rep.size(), 0);
        chk("starts_left", exp_starts, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hls_run_sequencer.md
Name: hls_run_sequencer

Overview:
Sequences one run of a Bambu-generated accelerator, such as the mergesort `main`, through its slave RAM port and start/done handshake. Per run it:
- streams N_WORDS input bytes into accelerator memory;
- pulses the accelerator start, counts run cycles and enforces a timeout;
- reads the result array back onto an output stream;
- reports status.

It replaces the file-driven testbench sequencing for on-chip/FPGA characterisation runs and sits between a host stream interface and the accelerator's slave memory port.

Parameters:
ADDR_W, 7, per-channel slave address width
DATA_W, 8, per-channel slave data width (one array element)
SIZE_W, 4, per-channel data_ram_size width
N_WORDS, 28, elements loaded and read back per run (1..2^ADDR_W)
BASE_ADDR, 0, slave address of element 0
CYC_W, 32, run cycle counter width
TIMEOUT_CYCLES, 200000000, run cycles before abort (must be < 2^CYC_W)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_start  in  1  start-run request, sampled only in IDLE
busy  out  1  high in every state except IDLE
in_valid  in  1  input element valid
in_ready  out  1  high only in LOAD
in_data  in  DATA_W  input element
out_valid  out  1  result element valid
out_ready  in  1  result consumer ready
out_data  out  DATA_W  result element
acc_start_port  out  1  to accelerator start_port
acc_done_port  in  1  from accelerator done_port
S_oe_ram  out  2  slave read enable; bit 0 used, bit 1 tied 0
S_we_ram  out  2  slave write enable; bit 0 used, bit 1 tied 0
S_addr_ram  out  2*ADDR_W  channel 0 in [ADDR_W-1:0], rest 0
S_Wdata_ram  out  2*DATA_W  channel 0 in [DATA_W-1:0], rest 0
S_data_ram_size  out  2*SIZE_W  channel 0 = DATA_W during access, else 0
Sout_Rdata_ram  in  2*DATA_W  slave read data; channel 0 used
Sout_DataRdy  in  2  slave read data ready; bit 0 used
run_cycles  out  CYC_W  cycle count of last run
status  out  2  00 none, 01 ok, 10 timeout, 11 sort error (optional feature only)
status_valid  out  1  one-cycle pulse on run completion

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs, counters and the output register are cleared. No slave access is generated. Reset mid-run abandons the run and does not pulse status_valid.
- IDLE:
  - cmd_start=1 → LOAD, idx=0. cmd_start is ignored in all other states.
  - status and run_cycles hold their last values.
- LOAD:
  - in_ready=1. Each in_valid&in_ready is accepted.
  - The cycle after acceptance: S_we_ram[0]=1, S_addr_ram=BASE_ADDR+idx, S_Wdata_ram=element, for exactly 1 cycle.
  - Back-to-back acceptances give back-to-back writes.
  - After acceptance N_WORDS-1, in_ready drops the next cycle. The final write issues in that cycle, then the state moves to KICK.
- KICK: acc_start_port=1 for exactly one cycle; run_cycles cleared to 0; → RUN. acc_done_port is ignored in KICK.
- RUN:
  - run_cycles increments by 1 each cycle, saturating at all-ones. The cycle in which done is sampled is included.
  - acc_done_port=1 → DRAIN, idx=0.
  - If run_cycles==TIMEOUT_CYCLES with no done: → REPORT with status 10. The drain is skipped.
  - If done and timeout coincide, done wins.
- DRAIN, one outstanding read at a time:
  - With the output register empty: S_oe_ram[0]=1 for 1 cycle, address BASE_ADDR+idx.
  - Then wait for Sout_DataRdy[0]. Latency is variable, nominally 2 cycles. Sout_DataRdy with no read outstanding is ignored.
  - On DataRdy: capture channel 0 data into out_data and set out_valid=1.
  - out_data/out_valid hold stable until out_ready. A handshake in the same cycle frees the register, and the next read may issue in the following cycle.
  - After handshake N_WORDS-1 → REPORT with status 01.
- REPORT: status_valid=1 for one cycle; status and run_cycles valid and held; → IDLE.
- Writes and reads are never issued in the same cycle. S_data_ram_size is nonzero only with oe or we.

Optional Feature:
HLS_SEQ_SORT_CHECK_EN
- Defined: during DRAIN each captured element is compared, unsigned, with the previous one. A decrease sets a sticky error, and REPORT then gives status 11 instead of 01. The error is cleared in KICK.
- Undefined: there is no comparator, and status 11 is never produced.

Test Plan:
- Reset then load 28 elements 27..0 back-to-back → 28 single-cycle writes at addresses 0..27 with matching data, in_ready low afterward, one acc_start_port pulse.
- Accelerator model raises done 100 cycles after start → run_cycles=100, status=01, status_valid a single pulse, 28 reads in address order.
- Drain with out_ready toggled 1/0 every cycle and DataRdy latency 2–5 → no lost or duplicated element, out_data stable while stalled, at most one outstanding read.
- Done never asserted, TIMEOUT_CYCLES=50 → status=10 at run_cycles=50, no S_oe_ram pulses, busy falls the cycle after REPORT.
- cmd_start held high throughout a run, plus reset asserted mid-DRAIN → no restart while busy; after reset all outputs 0, no status_valid.
- With HLS_SEQ_SORT_CHECK_EN, readback 0,1,2,5,4,… → status=11; with sorted readback → 01; without the macro, both give 01.
